uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO that feeds a run/feedback byte transmitter
//
// Purpose: buffers bytes written by the host and hands them one at a time to
// a downstream byte transmitter using a run/feedback handshake. A frame is
// finished when the transmitter raises feedback while run is high. Run is then
// dropped, and the feeder waits for feedback to return low before the next byte.
//
// Ports:
//   clock_50mhz  in   system clock (only clock in the block)
//   reset        in   asynchronous, active-high reset
//   wr_en        in   push wr_data into the FIFO this cycle
//   wr_data      in   [7:0] byte to transmit
//   full         out  FIFO holds DEPTH bytes
//   empty        out  FIFO holds 0 bytes
//   level        out  [log2(DEPTH):0] FIFO occupancy
//   overflow     out  sticky: a write arrived while full and was dropped
//   timeout_err  out  sticky: a feedback edge did not arrive in time
//   busy         out  handshake state machine is not idle
//   tx_data      out  [7:0] byte presented to the transmitter
//   tx_run       out  run request to the transmitter
//   tx_feedback  in   transmitter feedback, asynchronous to clock_50mhz
//   bytes_sent   out  [15:0] completed frames, wraps at 16 bits
module uart_tx_feeder #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock_50mhz,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_run,
  input  logic                     tx_feedback,
  output logic [15:0]              bytes_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  // Timer value seen during the last permitted cycle in SEND/RELEASE.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_q, busy_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_run_q, tx_run_d;
  logic [15:0]     bytes_sent_q, bytes_sent_d;
  logic            fb_meta_q, fb_meta_d;
  logic            fb_s_q, fb_s_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            push, pop;

  // Two-flop synchroniser; only fb_s_q is used by the state machine.
  always_comb begin
    fb_meta_d = tx_feedback;
    fb_s_d    = fb_meta_q;
  end

  // FIFO bookkeeping. Full is the registered flag, so a write in a cycle where
  // LOAD also pops is still refused if the FIFO was full before that edge.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = (state_q == LOAD);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
    full_d     = (level_d == LVL_FULL);
    empty_d    = (level_d == '0);
    overflow_d = overflow_q | (wr_en & full_q);
  end

  // Handshake state machine.
  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    bytes_sent_d  = bytes_sent_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // LOAD is only entered with a non-empty FIFO and is the only popper.
        tx_data_d = mem_q[rd_ptr_q];
        state_d   = SEND;
      end
      SEND: begin
        if (fb_s_q) begin
          bytes_sent_d = bytes_sent_q + 16'd1;
          state_d      = RELEASE;
        end else if (tmr_q == TMO_LAST) begin
          // The byte is abandoned; it is not counted as sent.
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        if (!fb_s_q) begin
          state_d = IDLE;
        end else if (tmr_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The timer only runs while waiting on feedback and restarts on every
    // state change, so it never passes TMO_LAST.
    if ((state_d != state_q) || !((state_q == SEND) || (state_q == RELEASE))) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    // Run and busy are registered images of the next state, so tx_run rises
    // on the LOAD->SEND edge and falls on the edge that leaves SEND.
    tx_run_d = (state_d == SEND);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_run_q      <= 1'b0;
      bytes_sent_q  <= 16'd0;
      fb_meta_q     <= 1'b0;
      fb_s_q        <= 1'b0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      tx_data_q     <= tx_data_d;
      tx_run_q      <= tx_run_d;
      bytes_sent_q  <= bytes_sent_d;
      fb_meta_q     <= fb_meta_d;
      fb_s_q        <= fb_s_d;
      tmr_q         <= tmr_d;
    end
  end

  // Storage is not reset; resetting the pointers discards its contents.
  always_ff @(posedge clock_50mhz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;
  assign tx_data     = tx_data_q;
  assign tx_run      = tx_run_q;
  assign bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full, empty, overflow, timeout_err, busy, tx_run, tx_feedback;
  logic [4:0]  level;
  logic [7:0]  tx_data;
  logic [15:0] bytes_sent;

  logic        t_wr_en;
  logic [7:0]  t_wr_data;
  logic        t_full, t_empty, t_overflow, t_timeout_err, t_busy, t_tx_run;
  logic [4:0]  t_level;
  logic [7:0]  t_tx_data;
  logic [15:0] t_bytes_sent;

  uart_tx_feeder dut (
    .clock_50mhz (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .busy        (busy),
    .tx_data     (tx_data),
    .tx_run      (tx_run),
    .tx_feedback (tx_feedback),
    .bytes_sent  (bytes_sent)
  );

  uart_tx_feeder #(.DEPTH(16), .TIMEOUT_CYCLES(1000)) dut_t (
    .clock_50mhz (clk),
    .reset       (reset),
    .wr_en       (t_wr_en),
    .wr_data     (t_wr_data),
    .full        (t_full),
    .empty       (t_empty),
    .level       (t_level),
    .overflow    (t_overflow),
    .timeout_err (t_timeout_err),
    .busy        (t_busy),
    .tx_data     (t_tx_data),
    .tx_run      (t_tx_run),
    .tx_feedback (1'b0),
    .bytes_sent  (t_bytes_sent)
  );

  // Byte transmitter model: start bit, 8 data bits LSB first, stop bit, each
  // baud_div cycles long; feedback rises after the stop bit and falls once
  // run has been dropped.
  int          baud_div = 434;
  logic        fb_hold = 1'b0;
  logic        fb_model = 1'b0;
  int          m_state = 0;
  int          m_cnt = 0;
  int          m_bit = 0;
  logic [9:0]  m_shift = '0;
  logic [7:0]  sent_q [$];
  logic        line_q [$];

  assign tx_feedback = fb_hold ? 1'b0 : fb_model;

  always @(posedge clk) begin
    if (reset) begin
      m_state  <= 0;
      fb_model <= 1'b0;
      m_cnt    <= 0;
      m_bit    <= 0;
    end else begin
      case (m_state)
        0: if (tx_run) begin
          m_shift  <= {1'b1, tx_data, 1'b0};
          m_bit    <= 0;
          m_cnt    <= 0;
          line_q.push_back(1'b0);
          sent_q.push_back(tx_data);
          m_state  <= 1;
        end
        1: if (m_cnt == baud_div - 1) begin
          m_cnt <= 0;
          if (m_bit == 9) begin
            fb_model <= 1'b1;
            m_state  <= 2;
          end else begin
            m_bit <= m_bit + 1;
            line_q.push_back(m_shift[m_bit + 1]);
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
        default: if (!tx_run) begin
          fb_model <= 1'b0;
          m_state  <= 0;
        end
      endcase
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    sent_q.delete();
    line_q.delete();
  endtask

  task automatic wait_sent(input int n, input int budget, input string name);
    int c = 0;
    while (bytes_sent != 16'(n) && c < budget) begin
      cyc();
      c++;
    end
    chk(name, bytes_sent, n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy && c < budget) begin
      cyc();
      c++;
    end
    chk(name, busy, 0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic [4:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       run;
  } vec_t;

  vec_t vt [19];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_line;
    int         n;
    int         seen;

    // Overflow table: feedback held low, so the first byte sits in SEND while
    // the FIFO fills; the 18th write (FF) meets a full FIFO.
    vt[0]  = '{1'b1, 8'h20, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h21, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 8'h22, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 8'h23, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 8'h24, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 8'h25, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 8'h26, 5'd6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 8'h27, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 8'h28, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 8'h29, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b1, 8'h2A, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b1, 8'h2B, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[12] = '{1'b1, 8'h2C, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[13] = '{1'b1, 8'h2D, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[14] = '{1'b1, 8'h2E, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[15] = '{1'b1, 8'h2F, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[16] = '{1'b1, 8'h30, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[17] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[18] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    t_wr_en   = 1'b0;
    t_wr_data = 8'h00;
    cyc();
    cyc();

    // Reset state
    chk("rst.tx_run", tx_run, 0);
    chk("rst.tx_data", tx_data, 8'h00);
    chk("rst.level", level, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.busy", busy, 0);
    chk("rst.bytes_sent", bytes_sent, 0);
    reset = 1'b0;
    cyc();

    // Single byte A5 at full baud
    baud_div = 434;
    sent_q.delete();
    line_q.delete();
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    chk("single.w0.level", level, 1);
    chk("single.w0.empty", empty, 0);
    chk("single.w0.tx_run", tx_run, 0);
    chk("single.w0.busy", busy, 0);
    cyc();
    chk("single.w1.busy", busy, 1);
    chk("single.w1.tx_run", tx_run, 0);
    cyc();
    chk("single.w2.tx_run", tx_run, 1);
    chk("single.w2.tx_data", tx_data, 8'hA5);
    chk("single.w2.empty", empty, 1);
    wait_sent(1, 6000, "single.bytes_sent");
    wait_idle(50, "single.busy_done");
    exp_line = 10'b1101001010;
    chk("single.line_len", line_q.size(), 10);
    for (int i = 0; i < 10 && i < line_q.size(); i++) begin
      chk($sformatf("single.line[%0d]", i), line_q[i], exp_line[i]);
    end

    // Burst of 16 bytes
    baud_div = 8;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    chk("burst.level", level, 15);
    chk("burst.full", full, 0);
    wait_sent(16, 4000, "burst.bytes_sent");
    chk("burst.count", sent_q.size(), 16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
      chk($sformatf("burst.byte[%0d]", i), sent_q[i], i);
    end

    // Overflow table
    do_reset();
    fb_hold = 1'b1;
    for (int i = 0; i < 19; i++) begin
      wr_en   = vt[i].we;
      wr_data = vt[i].data;
      cyc();
      chk($sformatf("ovf[%0d].level", i), level, vt[i].lvl);
      chk($sformatf("ovf[%0d].full", i), full, vt[i].full);
      chk($sformatf("ovf[%0d].empty", i), empty, vt[i].empty);
      chk($sformatf("ovf[%0d].overflow", i), overflow, vt[i].ovf);
      chk($sformatf("ovf[%0d].busy", i), busy, vt[i].busy);
      chk($sformatf("ovf[%0d].tx_run", i), tx_run, vt[i].run);
    end
    wr_en   = 1'b0;
    fb_hold = 1'b0;
    wait_sent(17, 5000, "ovf.bytes_sent");
    wait_idle(50, "ovf.busy_done");
    chk("ovf.count", sent_q.size(), 17);
    for (int i = 0; i < 17 && i < sent_q.size(); i++) begin
      chk($sformatf("ovf.byte[%0d]", i), sent_q[i], 8'h20 + i);
    end
    chk("ovf.sticky", overflow, 1);

    // Reset during SEND with five bytes queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h50 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    chk("rstmid.pre.level", level, 5);
    chk("rstmid.pre.tx_run", tx_run, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("rstmid.tx_run", tx_run, 0);
    chk("rstmid.empty", empty, 1);
    chk("rstmid.level", level, 0);
    @(posedge clk);
    cyc();
    reset = 1'b0;
    sent_q.delete();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (tx_run) seen++;
    end
    chk("rstmid.no_resend_run", seen, 0);
    chk("rstmid.no_resend_bytes", sent_q.size(), 0);
    chk("rstmid.bytes_sent", bytes_sent, 0);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    cyc();
    wr_en = 1'b0;
    wait_sent(1, 500, "rstmid.new.bytes_sent");
    chk("rstmid.new.count", sent_q.size(), 1);
    if (sent_q.size() > 0) chk("rstmid.new.byte", sent_q[0], 8'h77);

    // Pointer wrap: 40 bytes in groups of 10
    do_reset();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 10; i++) begin
        wr_en   = 1'b1;
        wr_data = 8'h80 + 8'(g * 10 + i);
        cyc();
      end
      wr_en = 1'b0;
      wait_sent((g + 1) * 10, 3000, $sformatf("wrap.g%0d.bytes_sent", g));
    end
    chk("wrap.count", sent_q.size(), 40);
    for (int i = 0; i < 40 && i < sent_q.size(); i++) begin
      chk($sformatf("wrap.byte[%0d]", i), sent_q[i], 8'h80 + i);
    end

    // Timeout with feedback stuck low (TIMEOUT_CYCLES = 1000)
    do_reset();
    t_wr_en   = 1'b1;
    t_wr_data = 8'h3C;
    cyc();
    t_wr_en = 1'b0;
    n = 0;
    while (!t_tx_run && n < 10) begin
      cyc();
      n++;
    end
    chk("tmo.rise", t_tx_run, 1);
    chk("tmo.tx_data", t_tx_data, 8'h3C);
    chk("tmo.err_before", t_timeout_err, 0);
    n = 0;
    while (t_tx_run && n < 2000) begin
      cyc();
      n++;
    end
    chk("tmo.fall_cycles", n, 1000);
    chk("tmo.timeout_err", t_timeout_err, 1);
    chk("tmo.bytes_sent", t_bytes_sent, 0);
    chk("tmo.busy_release", t_busy, 1);
    cyc();
    chk("tmo.busy_idle", t_busy, 0);
    chk("tmo.empty", t_empty, 1);
    repeat (5) cyc();
    chk("tmo.err_sticky", t_timeout_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
